// File: rtl/data_mem_loader.sv
// Streams len words into port A of a data memory, reads them back and
// compares the modular sum of written words against the sum of read words.
module data_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_a,
  output logic [DATA_W-1:0] data_a,
  output logic              wren_a,
  input  logic [DATA_W-1:0] q_a,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, CHECK} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_sat, len_q, cnt, rd;
  logic [DATA_W-1:0] wsum, rsum;
  logic              rd_vld_p1;
  logic              start_ok, accept;

  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign in_ready = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    len_sat   = (len > DEPTH_L) ? DEPTH_L : len;
    case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (len_sat == '0) ? CHECK : WRITE;
        end
      end
      WRITE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt + ONE_L == len_q) state_nxt = GAP;
        end
      end
      GAP:     state_nxt = READ;
      READ:    if (rd == len_q) state_nxt = DRAIN;
      DRAIN:   state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: read data returns one cycle after its address, so the sample
  // strobe is the READ state delayed by one cycle (covers DRAIN as well).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_a <= '0;
      data_a    <= '0;
      wren_a    <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      rd        <= '0;
      wsum      <= '0;
      rsum      <= '0;
      rd_vld_p1 <= 1'b0;
      pass      <= 1'b0;
    end else begin
      wren_a    <= 1'b0;
      rd_vld_p1 <= (state == READ);
      if (rd_vld_p1) rsum <= add_wrap(rsum, q_a);
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q <= len_sat;
            cnt   <= '0;
            rd    <= '0;
            wsum  <= '0;
            rsum  <= '0;
            pass  <= (len_sat == '0);
          end
        end
        WRITE: begin
          if (accept) begin
            wren_a    <= 1'b1;
            address_a <= cnt[ADDR_W-1:0];
            data_a    <= in_data;
            cnt       <= cnt + ONE_L;
            wsum      <= add_wrap(wsum, in_data);
          end
        end
        GAP: begin
          address_a <= '0;
          rd        <= ONE_L;
        end
        READ: begin
          if (rd != len_q) begin
            address_a <= rd[ADDR_W-1:0];
            rd        <= rd + ONE_L;
          end
        end
        DRAIN: pass <= (wsum == add_wrap(rsum, q_a));
        default: ;
      endcase
    end
  end
endmodule
